// File: rtl/router_output_channel.sv
// router_output_channel
// Transmit side of a router port. Packets from the crossbar land in one of two
// single-entry virtual channels picked by the global even/odd polarity bit, and
// the opposite VC drains onto the inter-router link under send/ready.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   polarity        global phase bit (0 = even, 1 = odd); write VC = polarity,
//                   read VC = !polarity
//   in_valid/in_data/in_ready
//                   crossbar side; in_ready is combinational, all-zero data is idle
//   out_ready/out_send/out_data
//                   link side; out_send/out_data registered, out_data = 0 when idle
//   pkt_count       transmitted-packet counter (wraps)
//   stall_count     blocked-cycle counter (saturates)
//
// Build option: define ROUTER_OUT_STATS_EN to build the two counters; otherwise
// they are tied to zero and no counter logic exists.

module router_output_channel (
  input  logic        clk,
  input  logic        reset,
  input  logic        polarity,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_send,
  output logic [63:0] out_data,
  output logic [15:0] pkt_count,
  output logic [15:0] stall_count
);

  localparam int unsigned DataW = 64;
  localparam int unsigned CntW  = 16;

  typedef enum logic {
    VC_EMPTY = 1'b0,
    VC_FULL  = 1'b1
  } vc_state_e;

  vc_state_e              vc_state_q [2];
  vc_state_e              vc_state_d [2];
  logic [DataW-1:0]       vc_data_q  [2];
  logic [DataW-1:0]       vc_data_d  [2];
  logic                   out_send_q, out_send_d;
  logic [DataW-1:0]       out_data_q, out_data_d;

  logic wr_vc;
  logic rd_vc;
  logic wr_fire;
  logic rd_fire;
  logic rd_stall;

  // Write and read VCs are always opposite, so they never collide.
  assign wr_vc    = polarity;
  assign rd_vc    = ~polarity;

  assign in_ready = ~reset && (vc_state_q[wr_vc] == VC_EMPTY);
  // Zero data is the link idle code, so it is never stored.
  assign wr_fire  = in_valid && in_ready && (in_data != '0);
  assign rd_fire  = (vc_state_q[rd_vc] == VC_FULL) && out_ready;
  assign rd_stall = (vc_state_q[rd_vc] == VC_FULL) && !out_ready;

  // VC state register and link output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vc_state_q[0] <= VC_EMPTY;
      vc_state_q[1] <= VC_EMPTY;
      vc_data_q[0]  <= '0;
      vc_data_q[1]  <= '0;
      out_send_q    <= 1'b0;
      out_data_q    <= '0;
    end else begin
      vc_state_q[0] <= vc_state_d[0];
      vc_state_q[1] <= vc_state_d[1];
      vc_data_q[0]  <= vc_data_d[0];
      vc_data_q[1]  <= vc_data_d[1];
      out_send_q    <= out_send_d;
      out_data_q    <= out_data_d;
    end
  end

  // Per-VC EMPTY/FULL next state plus link output.
  always_comb begin
    vc_state_d[0] = vc_state_q[0];
    vc_state_d[1] = vc_state_q[1];
    vc_data_d[0]  = vc_data_q[0];
    vc_data_d[1]  = vc_data_q[1];
    out_send_d    = 1'b0;
    out_data_d    = '0;

    if (wr_fire) begin
      vc_state_d[wr_vc] = VC_FULL;
      vc_data_d[wr_vc]  = in_data;
    end

    if (rd_fire) begin
      vc_state_d[rd_vc] = VC_EMPTY;
      out_send_d        = 1'b1;
      out_data_d        = vc_data_q[rd_vc];
    end
  end

  assign out_send = out_send_q;
  assign out_data = out_data_q;

`ifdef ROUTER_OUT_STATS_EN
  logic [CntW-1:0] pkt_count_q, pkt_count_d;
  logic [CntW-1:0] stall_count_q, stall_count_d;

  // Packet counter wraps; stall counter saturates so a long stall stays visible.
  always_comb begin
    pkt_count_d   = pkt_count_q + CntW'(rd_fire);
    stall_count_d = stall_count_q;
    if (rd_stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`else
  logic unused_stall;
  assign unused_stall = rd_stall;
  assign pkt_count    = CntW'(0);
  assign stall_count  = CntW'(0);
`endif

endmodule

// File: doc/router_output_channel.md
# router_output_channel

Transmit side of a router port: accepts 64-bit packets from the router crossbar, holds them in two single-entry virtual channels selected by the global even/odd polarity, and drives them onto the inter-router link under the downstream input channel's send/ready handshake. One instance sits on each of a router's output ports, and its link outputs connect directly to the neighbour's input channel.

## Interface
- No parameters; data width fixed at 64 bits.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- polarity  input  1  global phase bit, toggles every cycle; 0 = even, 1 = odd.
- in_valid  input  1  crossbar presents a packet on in_data.
- in_data  input  64  packet from crossbar; all-zero value means idle.
- in_ready  output  1  combinational; VC selected by current polarity can accept.
- out_ready  input  1  downstream input channel can accept this cycle.
- out_send  output  1  registered; out_data carries a valid packet.
- out_data  output  64  registered; packet to downstream, 0 when idle.
- pkt_count  output  16  transmitted-packet counter (see Configuration).
- stall_count  output  16  blocked-cycle counter (see Configuration).

## Operation
- State: vc_data[0], vc_data[1] (64 b each) and vc_full[0], vc_full[1]. Each VC is a 2-state FSM, EMPTY or FULL.
- Write side: the write VC is w = polarity.
  - in_ready = !reset && !vc_full[w].
  - On a clock edge with in_valid && in_ready && in_data != 0: vc_data[w] <= in_data and vc_full[w] <= 1 (EMPTY->FULL).
  - An all-zero in_data is dropped and no state changes, because downstream treats zero as idle.
  - If in_valid is high while in_ready is low, the crossbar holds the packet. No state changes.
- Read side: the read VC is r = !polarity.
  - On a clock edge with vc_full[r] && out_ready: out_send <= 1, out_data <= vc_data[r], vc_full[r] <= 0 (FULL->EMPTY).
  - Otherwise out_send <= 0 and out_data <= 0.
- Write and read always target different VCs in the same cycle, so no same-entry conflict exists. A write to one VC and a transmit from the other may occur on the same edge.
- If polarity is held constant, only vc[!polarity] drains. Behaviour stays defined and no data is corrupted.
- The block performs no routing decisions. Packet contents pass through unmodified.

## Timing
- Reset, synchronous: on an edge with reset high, vc_full[1:0] <= 0, vc_data <= 0, out_send <= 0, out_data <= 0, pkt_count <= 0, stall_count <= 0.
- in_ready is 0 for the whole cycle in which reset is high.
- Reset asserted mid-operation discards both VCs. The next edge has no transmission.
- Latency:
  - A packet accepted at edge k, with polarity p during cycle k-1, sits in VC p.
  - VC p is read in the cycle where polarity = !p, which is the next cycle if polarity toggles.
  - Earliest out_send is therefore at edge k+1, a minimum latency of 1 cycle from acceptance.
- A stall (out_ready low) holds the packet. Retry occurs every other cycle, whenever that VC is again the read VC.
- Throughput: one packet per cycle sustained when out_ready stays high, alternating VCs.
- Both VCs full: in_ready = 0 in both phases until a transmit frees one.

## Configuration
- Macro: ROUTER_OUT_STATS_EN.
- Defined:
  - pkt_count increments by 1 on every edge that transmits, wrapping 0xFFFF -> 0x0000.
  - stall_count increments by 1 on every edge where vc_full[r] && !out_ready, saturating at 0xFFFF.
  - Both counters clear on reset.
- Not defined: pkt_count and stall_count are tied to 16'h0000 and no counter logic is synthesized.
- Datapath behaviour is identical either way.

## Test plan
- Reset with reset=1 for 2 cycles -> out_send=0, out_data=0, in_ready=0 while reset is high. After release, in_ready=1 and the counters read 0.
- Single packet:
  - Stimulus: in_data=64'hA5 accepted with polarity=0 (vc0), out_ready=1.
  - Required: next edge (polarity=1) gives out_send=1, out_data=64'hA5, then out_send=0, out_data=0.
- Back-to-back:
  - Stimulus: packets 1,2,3,4 on consecutive cycles with polarity toggling and out_ready=1.
  - Required: out_data shows 1,2,3,4 on consecutive cycles, one cycle delayed, with in_ready constantly 1.
- Stall:
  - Stimulus: fill vc0 and vc1 (0x11, 0x22), hold out_ready=0 for 6 cycles.
  - Required: in_ready=0 in both phases and out_send=0. With ROUTER_OUT_STATS_EN, stall_count=6.
  - Then out_ready=1: 0x11 and 0x22 emerge on the next two read opportunities.
- Zero drop: in_valid=1, in_data=0 -> no VC fills and out_send stays 0. pkt_count is unchanged.
- Mid-operation reset:
  - Stimulus: both VCs full, then reset pulses for 1 cycle.
  - Required: no packet is ever transmitted and in_ready=1 afterwards.
  - Required: a new packet 0x33 then transmits normally and pkt_count=1.
